canny_frame_tx_ctrl: RTL and testbench

- Sequences transmission of one stored Canny edge frame from the frame RAM into `uart_tx_fifo`.
- On `start` it emits a fixed packet: 2 sync bytes, a 2-byte pixel count, PIXELS data bytes read from RAM, then 1 end byte.
- It pushes bytes through the FIFO's push/full interface and never pushes while the FIFO is full.
- Sits between the frame RAM read port and `uart_tx_fifo`; the host PC parses the packet.

---
 rtl/canny_frame_tx_ctrl.sv | 145 ++++++++++++++
 tb/tb_canny_frame_tx_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_tx_ctrl.sv
// Streams one stored Canny edge frame from the frame RAM into uart_tx_fifo as a framed packet.
// Optional `CANNY_TX_CHECKSUM_EN adds an XOR checksum byte between the data and the trailer.
module canny_frame_tx_ctrl #(
  parameter int unsigned PIXELS   = 40800,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [7:0]  SYNC0    = 8'hA5,
  parameter logic [7:0]  SYNC1    = 8'h5A,
  parameter logic [7:0]  END_BYTE = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              push,
  input  logic              tx_fifo_full
);

  localparam int unsigned   CW     = ADDR_W + 1;
  localparam logic [CW-1:0] PIX_C  = CW'(PIXELS);
  localparam logic [CW-1:0] LAST_C = CW'(PIXELS - 1);
  localparam logic [15:0]   PIX16  = 16'(PIXELS);

  typedef enum logic [3:0] {
    IDLE, SYNC_A, SYNC_B, LEN_H, LEN_L, STREAM,
`ifdef CANNY_TX_CHECKSUM_EN
    CSUM,
`endif
    TRAIL, FIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, push_cnt_q;
  logic            inflight_q;
  logic [7:0]      buf_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      occ_q;
  logic [7:0]      tx_last_q;
`ifdef CANNY_TX_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic            byte_avail, pop, last_data, prefetch, accept;
  logic [7:0]      byte_cur;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = SYNC_A;
      SYNC_A: if (push) state_d = SYNC_B;
      SYNC_B: if (push) state_d = LEN_H;
      LEN_H:  if (push) state_d = LEN_L;
      LEN_L:  if (push) state_d = STREAM;
      STREAM: if (last_data) begin
`ifdef CANNY_TX_CHECKSUM_EN
        state_d = CSUM;
`else
        state_d = TRAIL;
`endif
      end
`ifdef CANNY_TX_CHECKSUM_EN
      CSUM:   if (push) state_d = TRAIL;
`endif
      TRAIL:  if (push) state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_avail = 1'b0;
    byte_cur   = tx_last_q;
    case (state_q)
      SYNC_A: begin byte_avail = 1'b1; byte_cur = SYNC0;       end
      SYNC_B: begin byte_avail = 1'b1; byte_cur = SYNC1;       end
      LEN_H:  begin byte_avail = 1'b1; byte_cur = PIX16[15:8]; end
      LEN_L:  begin byte_avail = 1'b1; byte_cur = PIX16[7:0];  end
      STREAM: begin byte_avail = (occ_q != 2'd0); byte_cur = buf_q[rd_ptr_q]; end
`ifdef CANNY_TX_CHECKSUM_EN
      CSUM:   begin byte_avail = 1'b1; byte_cur = csum_q;      end
`endif
      TRAIL:  begin byte_avail = 1'b1; byte_cur = END_BYTE;    end
      default: ;
    endcase
    push      = byte_avail && !tx_fifo_full;
    tx_data   = push ? byte_cur : tx_last_q;
    pop       = push && (state_q == STREAM);
    last_data = pop && (push_cnt_q == LAST_C);
    // Reads start during the length bytes so the skid buffer is primed when STREAM begins.
    prefetch  = (state_q == LEN_H) || (state_q == LEN_L) || (state_q == STREAM);
    rd_en     = prefetch && (rd_cnt_q < PIX_C) &&
                ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    rd_addr   = rd_cnt_q[ADDR_W-1:0];
    busy      = (state_q != IDLE) && (state_q != FIN);
    done      = (state_q == FIN);
    accept    = (state_q == IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q   <= '0;
      push_cnt_q <= '0;
      inflight_q <= 1'b0;
      buf_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
      tx_last_q  <= '0;
`ifdef CANNY_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      inflight_q <= rd_en;
      if (rd_en) rd_cnt_q <= rd_cnt_q + CW'(1);
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        push_cnt_q <= push_cnt_q + CW'(1);
      end
      occ_q <= occ_q + 2'(inflight_q) - 2'(pop);
      if (push) tx_last_q <= byte_cur;
`ifdef CANNY_TX_CHECKSUM_EN
      if (accept)   csum_q <= '0;
      else if (pop) csum_q <= csum_q ^ byte_cur;
`endif
      if (accept || (state_d == FIN)) begin
        rd_cnt_q   <= '0;
        push_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_canny_frame_tx_ctrl.sv
// Bench for canny_frame_tx_ctrl: small 4-pixel instance driven from a vector table,
// larger instance for reset-abort and full-toggling stress; scoreboard queue per instance.
module tb_canny_frame_tx_ctrl;

  localparam int unsigned PIX_S = 4;
  localparam int unsigned PIX_B = 2000;
  localparam int unsigned AW_B  = 11;
`ifdef CANNY_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int LEN_S = PIX_S + 5 + CS;
  localparam int LEN_B = PIX_B + 5 + CS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_reset, s_start, s_busy, s_done, s_rd_en, s_push, s_full;
  logic [15:0] s_rd_addr;
  logic [7:0]  s_rd_data, s_tx_data;
  logic b_reset, b_start, b_busy, b_done, b_rd_en, b_push, b_full;
  logic [AW_B-1:0] b_rd_addr;
  logic [7:0]      b_rd_data, b_tx_data;

  canny_frame_tx_ctrl #(.PIXELS(PIX_S), .ADDR_W(16)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .tx_data(s_tx_data), .push(s_push), .tx_fifo_full(s_full));

  canny_frame_tx_ctrl #(.PIXELS(PIX_B), .ADDR_W(AW_B)) u_big (
    .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .tx_data(b_tx_data), .push(b_push), .tx_fifo_full(b_full));

  logic [7:0] sram [PIX_S];
  logic [7:0] bram [PIX_B];
  always @(posedge clk) if (s_rd_en) s_rd_data <= sram[s_rd_addr[1:0]];
  always @(posedge clk) if (b_rd_en) b_rd_data <= bram[b_rd_addr];

  typedef struct {
    logic [31:0] ram_w;
    int          f_from;
    int          f_to;
    bit          toggle;
    int          exp_len;
    int          exp_span;
  } vec_t;
  vec_t vecs [5];

  logic [7:0] s_q [$];
  logic [7:0] b_q [$];
  int n_pass = 0, n_total = 0, cyc = 0;
  int s_cnt, b_cnt, s_done_cnt, b_done_cnt, s_first, s_last;
  logic [15:0] s_addr_at_done;
  bit s_prev_end, b_prev_end, s_done_now, b_done_now;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (s_push) begin
      check("s_push_while_full", !s_full, s_full, 0);
      if (s_q.size() == 0) check("s_unexpected_push", 1'b0, s_tx_data, -1);
      else begin
        e = s_q.pop_front();
        check("s_byte", s_tx_data == e, s_tx_data, e);
      end
      if (s_cnt == 0) s_first = cyc;
      s_last = cyc;
      s_cnt++;
    end
    if (s_done) begin
      s_done_cnt++;
      s_addr_at_done = s_rd_addr;
      check("s_done_after_end", s_prev_end, s_prev_end, 1);
    end
    s_prev_end = s_push && (s_tx_data == 8'h55);
    s_done_now = s_done;
    if (b_push) begin
      check("b_push_while_full", !b_full, b_full, 0);
      if (b_q.size() == 0) check("b_unexpected_push", 1'b0, b_tx_data, -1);
      else begin
        e = b_q.pop_front();
        check("b_byte", b_tx_data == e, b_tx_data, e);
      end
      b_cnt++;
    end
    if (b_done) begin
      b_done_cnt++;
      check("b_done_after_end", b_prev_end, b_prev_end, 1);
    end
    b_prev_end = b_push && (b_tx_data == 8'h55);
    b_done_now = b_done;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_small(input logic [31:0] w);
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(PIX_S);
    x = '0;
    s_q.push_back(8'hA5); s_q.push_back(8'h5A);
    s_q.push_back(n[15:8]); s_q.push_back(n[7:0]);
    for (int i = 0; i < 4; i++) begin
      sram[i] = w[31-8*i -: 8];
      s_q.push_back(sram[i]);
      x = x ^ sram[i];
    end
    if (CS != 0) s_q.push_back(x);
    s_q.push_back(8'h55);
  endtask

  task automatic expect_big(input bit refill);
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(PIX_B);
    x = '0;
    b_q.push_back(8'hA5); b_q.push_back(8'h5A);
    b_q.push_back(n[15:8]); b_q.push_back(n[7:0]);
    for (int i = 0; i < int'(PIX_B); i++) begin
      if (refill) bram[i] = 8'($urandom);
      b_q.push_back(bram[i]);
      x = x ^ bram[i];
    end
    if (CS != 0) b_q.push_back(x);
    b_q.push_back(8'h55);
  endtask

  task automatic run_small(input vec_t r, input int idx);
    expect_small(r.ram_w);
    s_cnt = 0; s_done_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      s_start = (c == 0);
      s_full  = r.toggle ? c[0] : ((c >= r.f_from) && (c <= r.f_to));
      step();
      if (s_done_now) break;
    end
    s_start = 1'b0; s_full = 1'b0;
    check($sformatf("v%0d_timeout", idx), s_done_now, s_done_now, 1);
    step(); step();
    check($sformatf("v%0d_busy_after", idx), s_busy == 1'b0, s_busy, 0);
    check($sformatf("v%0d_count", idx), s_cnt == r.exp_len, s_cnt, r.exp_len);
    check($sformatf("v%0d_done_cnt", idx), s_done_cnt == 1, s_done_cnt, 1);
    check($sformatf("v%0d_rd_addr_fin", idx), s_addr_at_done == 16'd0, s_addr_at_done, 0);
    check($sformatf("v%0d_queue_left", idx), s_q.size() == 0, s_q.size(), 0);
    if (r.exp_span >= 0)
      check($sformatf("v%0d_span", idx), (s_last - s_first) == r.exp_span, s_last - s_first, r.exp_span);
  endtask

  initial begin
    s_reset = 1'b1; s_start = 1'b0; s_full = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_full = 1'b0;
    vecs[0] = '{32'h11223344, 0, -1, 1'b0, LEN_S, LEN_S - 1};
    vecs[1] = '{32'h11223344, 7, 16, 1'b0, LEN_S, -1};
    vecs[2] = '{32'h00FF8001, 2, 4, 1'b0, LEN_S, LEN_S - 1 + 3};
    vecs[3] = '{32'hDEADBEEF, 5, 6, 1'b0, LEN_S, LEN_S - 1 + 2};
    vecs[4] = '{32'h55AA0102, 0, -1, 1'b1, LEN_S, -1};
    s_cnt = 0; b_cnt = 0; s_done_cnt = 0; b_done_cnt = 0;
    s_first = 0; s_last = 0; s_addr_at_done = '0;
    s_prev_end = 0; b_prev_end = 0; s_done_now = 0; b_done_now = 0;
    #1;
    step(); step();

    check("rst_busy",    s_busy == 1'b0,     s_busy, 0);
    check("rst_done",    s_done == 1'b0,     s_done, 0);
    check("rst_rd_en",   s_rd_en == 1'b0,    s_rd_en, 0);
    check("rst_rd_addr", s_rd_addr == 16'd0, s_rd_addr, 0);
    check("rst_push",    s_push == 1'b0,     s_push, 0);
    check("rst_tx_data", s_tx_data == 8'h00, s_tx_data, 0);
    check("rst_b_busy",  b_busy == 1'b0,     b_busy, 0);
    s_reset = 1'b0; b_reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_small(vecs[i], i);

    // start re-pulsed while busy must be ignored
    expect_small(32'h11223344);
    s_cnt = 0; s_done_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      s_start = (c == 0) || (c == 4) || (c == 9);
      step();
      if (s_done_now) break;
    end
    s_start = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check("rebusy_count", s_cnt == LEN_S, s_cnt, LEN_S);
    check("rebusy_done_cnt", s_done_cnt == 1, s_done_cnt, 1);

    // start asserted together with reset must not launch a packet
    s_cnt = 0; s_done_cnt = 0;
    s_reset = 1'b1; s_start = 1'b1;
    step();
    s_start = 1'b0;
    step();
    s_reset = 1'b0;
    for (int c = 0; c < 30; c++) step();
    check("rststart_count", s_cnt == 0, s_cnt, 0);
    check("rststart_busy", s_busy == 1'b0, s_busy, 0);

    // abort mid-frame after 100 data bytes, then a clean frame
    b_cnt = 0; b_done_cnt = 0;
    expect_big(1'b1);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 0; c < 500 && b_cnt < 104; c++) step();
    check("abort_reach_100", b_cnt == 104, b_cnt, 104);
    b_reset = 1'b1; b_full = 1'b1;
    b_q.delete();
    step();
    check("abort_busy", b_busy == 1'b0, b_busy, 0);
    check("abort_push", b_push == 1'b0, b_push, 0);
    check("abort_rd_addr", b_rd_addr == '0, b_rd_addr, 0);
    b_full = 1'b0;
    step();
    b_reset = 1'b0;
    step();
    check("abort_no_done", b_done_cnt == 0, b_done_cnt, 0);
    b_cnt = 0;
    expect_big(1'b0);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      step();
      if (b_done_now) break;
    end
    check("restart_timeout", b_done_now, b_done_now, 1);
    check("restart_count", b_cnt == LEN_B, b_cnt, LEN_B);
    check("restart_done_cnt", b_done_cnt == 1, b_done_cnt, 1);
    step();

    // full toggling every cycle over a random frame
    b_cnt = 0; b_done_cnt = 0;
    expect_big(1'b1);
    for (int c = 0; c < 10000; c++) begin
      b_start = (c == 0);
      b_full  = c[0];
      step();
      if (b_done_now) break;
    end
    b_start = 1'b0; b_full = 1'b0;
    check("toggle_timeout", b_done_now, b_done_now, 1);
    step(); step();
    check("toggle_count", b_cnt == LEN_B, b_cnt, LEN_B);
    check("toggle_done_cnt", b_done_cnt == 1, b_done_cnt, 1);
    check("toggle_queue_left", b_q.size() == 0, b_q.size(), 0);
    check("toggle_busy_after", b_busy == 1'b0, b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
